// File: rtl/oser4_tx_pkg.sv
// Shared types and defaults for the oser4_tx serializer.
package oser_pkg;

  // Content class of the word currently held in the shifter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // Default filler words for a 4-bit word width.
  localparam logic [3:0] IDLE_DEF  = 4'b0000;
  localparam logic [3:0] TRAIN_DEF = 4'b0011;

  // pclk threshold: the word clock is high for bit positions below this value.
  function automatic int half(input int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/oser4_tx_if.sv
// Parallel word handshake between a fabric word source and the serializer.
interface oser4_tx_if #(
  parameter int DW = 4
) ();
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;

  // Word source side.
  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  // Serializer side.
  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/oser4_tx_hold.sv
// One-entry valid/ready holding register in front of the serializer shifter.
// ready is a flop of its own so it never depends on valid in the same cycle.
module oser_hold #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          valid,
  output logic          ready,
  output logic [DW-1:0] q,
  output logic          full,
  input  logic          drain
);

  logic          full_reg;
  logic          ready_reg;
  logic [DW-1:0] q_reg;
  logic          accept;

  // ready_reg is always the complement of full_reg, so accept only happens when empty.
  assign accept = valid && ready_reg;

  // Fill on accept, empty when the shifter takes the word; the two never coincide
  // because drain only happens while full (ready low).
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg  <= 1'b0;
      ready_reg <= 1'b1;
      q_reg     <= '0;
    end else begin
      if (drain && full_reg) begin
        full_reg  <= 1'b0;
        ready_reg <= 1'b1;
      end else if (accept) begin
        full_reg  <= 1'b1;
        ready_reg <= 1'b0;
      end
      if (accept) begin
        q_reg <= d;
      end
    end
  end

  assign ready = ready_reg;
  assign full  = full_reg;
  assign q     = q_reg;

endmodule

// File: rtl/oser4_tx.sv
// Soft-logic DW:1 serializer transmitter. Words are shifted out LSB first, one
// bit per clk, with a divided word clock and a bit-0 frame marker alongside.
// When no data word is waiting at a word boundary the TRAIN or IDLE word is sent.
module oser4_tx
  import oser_pkg::*;
#(
  parameter int            DW    = 4,
  parameter logic [DW-1:0] IDLE  = DW'(IDLE_DEF),
  parameter logic [DW-1:0] TRAIN = DW'(TRAIN_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  oser4_tx_if.slave  bus,
  input  logic       train_i,
  output logic       ser_o,
  output logic       pclk_o,
  output logic       frame_o,
  output logic       underrun_o
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam int            HALF = half(DW);

  logic [CW-1:0] cnt;
  logic [DW-1:0] shifter;
  state_t        state;

  logic [DW-1:0] hold_q;
  logic          hold_full;
  logic          boundary;
  logic          drain;

  // The cycle carrying the last bit of a word ends with a load of the next word.
  assign boundary = (cnt == LAST);
  assign drain    = boundary && hold_full;

  oser_hold #(
    .DW(DW)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.data_i),
    .valid (bus.valid_i),
    .ready (bus.ready_o),
    .q     (hold_q),
    .full  (hold_full),
    .drain (drain)
  );

  // Bit counter, shifter, word-class FSM and all line outputs, registered together
  // so ser_o, frame_o and pclk_o describe the same bit position in every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shifter    <= IDLE;
      state      <= ST_IDLE;
      ser_o      <= IDLE[0];
      frame_o    <= 1'b1;
      pclk_o     <= 1'b1;
      underrun_o <= 1'b0;
    end else if (boundary) begin
      cnt     <= '0;
      frame_o <= 1'b1;
      pclk_o  <= 1'b1;
      if (hold_full) begin
        shifter    <= hold_q;
        ser_o      <= hold_q[0];
        state      <= ST_DATA;
        underrun_o <= 1'b0;
      end else if (train_i) begin
        shifter    <= TRAIN;
        ser_o      <= TRAIN[0];
        state      <= ST_TRAIN;
        underrun_o <= (state == ST_DATA);
      end else begin
        shifter    <= IDLE;
        ser_o      <= IDLE[0];
        state      <= ST_IDLE;
        underrun_o <= (state == ST_DATA);
      end
    end else begin
      cnt        <= cnt + 1'b1;
      shifter    <= shifter >> 1;
      ser_o      <= shifter[1];
      frame_o    <= 1'b0;
      pclk_o     <= ((int'(cnt) + 1) < HALF);
      underrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oser4_tx.sv
// Self-checking bench for oser4_tx at DW=4 and DW=8 against a word-level model.
module tb_oser4_tx;

  logic clk;
  logic rst;
  logic train4, train8;
  logic ser4, pclk4, frame4, und4;
  logic ser8, pclk8, frame8, und8;

  oser4_tx_if #(.DW(4)) bus4 ();
  oser4_tx_if #(.DW(8)) bus8 ();

  oser4_tx #(.DW(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus4),
    .train_i    (train4),
    .ser_o      (ser4),
    .pclk_o     (pclk4),
    .frame_o    (frame4),
    .underrun_o (und4)
  );

  oser4_tx #(.DW(8), .IDLE(8'h00), .TRAIN(8'h0F)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus8),
    .train_i    (train8),
    .ser_o      (ser8),
    .pclk_o     (pclk8),
    .frame_o    (frame8),
    .underrun_o (und8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one slot per instance (0: DW=4, 1: DW=8).
  // Tracks which word is on the line, which bit of it is showing, the waiting
  // word (at most one) and the class of the word on the line (0 idle,1 train,2 data).
  int         dw_m   [2] = '{4, 8};
  logic [7:0] idle_m [2] = '{8'h00, 8'h00};
  logic [7:0] train_m[2] = '{8'h03, 8'h0F};
  int         pos_m  [2];
  logic [7:0] cur_m  [2];
  bit         hfull_m[2];
  logic [7:0] hval_m [2];
  int         kind_m [2];
  logic       und_m  [2];

  task automatic model_edge(input int k, input logic rst_v, input logic valid_v,
                            input logic [7:0] data_v, input logic train_v);
    bit acc;
    int nk;
    if (rst_v) begin
      pos_m[k]   = 0;
      cur_m[k]   = idle_m[k];
      hfull_m[k] = 0;
      kind_m[k]  = 0;
      und_m[k]   = 1'b0;
      return;
    end
    acc = valid_v && !hfull_m[k];
    if (pos_m[k] == dw_m[k] - 1) begin
      pos_m[k] = 0;
      if (hfull_m[k]) begin
        cur_m[k]   = hval_m[k];
        hfull_m[k] = 0;
        nk = 2;
      end else if (train_v) begin
        cur_m[k] = train_m[k];
        nk = 1;
      end else begin
        cur_m[k] = idle_m[k];
        nk = 0;
      end
      und_m[k]  = (kind_m[k] == 2) && (nk != 2);
      kind_m[k] = nk;
    end else begin
      pos_m[k] = pos_m[k] + 1;
      und_m[k] = 1'b0;
    end
    if (acc) begin
      hfull_m[k] = 1;
      hval_m[k]  = data_v;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("ser4",   ser4,          cur_m[0][pos_m[0]]);
    check("frame4", frame4,        pos_m[0] == 0);
    check("pclk4",  pclk4,         pos_m[0] < 2);
    check("ready4", bus4.ready_o,  !hfull_m[0]);
    check("und4",   und4,          und_m[0]);
    check("ser8",   ser8,          cur_m[1][pos_m[1]]);
    check("frame8", frame8,        pos_m[1] == 0);
    check("pclk8",  pclk8,         pos_m[1] < 4);
    check("ready8", bus8.ready_o,  !hfull_m[1]);
    check("und8",   und8,          und_m[1]);
  endtask

  // One clock: inputs are stable across the edge, model follows the edge,
  // outputs are compared 1 ns later.
  task automatic tick();
    logic       r, v4, v8, t4, t8;
    logic [7:0] d4, d8;
    r  = rst;
    v4 = bus4.valid_i; d4 = {4'b0000, bus4.data_i}; t4 = train4;
    v8 = bus8.valid_i; d8 = bus8.data_i;            t8 = train8;
    @(posedge clk);
    model_edge(0, r, v4, d4, t4);
    model_edge(1, r, v8, d8, t8);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word and hold valid until the handshake completes; valid is left high.
  task automatic send4(input logic [3:0] w);
    bit done = 0;
    bus4.data_i  = w;
    bus4.valid_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      logic r;
      r = bus4.ready_o;
      tick();
      if (r) done = 1;
    end
    check("send4_accept", done, 1'b1);
    $display("send dw=4 data=%h accepted=%0d t=%0t", w, done, $time);
  endtask

  task automatic send8(input logic [7:0] w);
    bit done = 0;
    bus8.data_i  = w;
    bus8.valid_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      logic r;
      r = bus8.ready_o;
      tick();
      if (r) done = 1;
    end
    check("send8_accept", done, 1'b1);
    $display("send dw=8 data=%h accepted=%0d t=%0t", w, done, $time);
  endtask

  initial begin
    rst = 1'b1;
    train4 = 1'b0; train8 = 1'b0;
    bus4.data_i = '0; bus4.valid_i = 1'b0;
    bus8.data_i = '0; bus8.valid_i = 1'b0;

    // Reset held 3 cycles, then an idle line.
    ticks(3);
    rst = 1'b0;
    ticks(12);

    // Single words on both widths.
    send4(4'b1011);
    bus4.valid_i = 1'b0;
    send8(8'hC3);
    bus8.valid_i = 1'b0;
    ticks(20);

    // Back-to-back stream with valid held high.
    send4(4'hA);
    send4(4'h5);
    send4(4'hF);
    bus4.valid_i = 1'b0;
    ticks(16);

    // Training, a data word preempting it, then training again.
    train4 = 1'b1; train8 = 1'b1;
    ticks(16);
    send4(4'h6);
    bus4.valid_i = 1'b0;
    ticks(16);
    train4 = 1'b0; train8 = 1'b0;
    ticks(8);

    // Reset while a word waits in the hold and the shifter is at bit 2.
    for (int i = 0; i < 20 && !(pos_m[0] == 1 && !hfull_m[0]); i++) tick();
    bus4.data_i = 4'h9; bus4.valid_i = 1'b1;
    tick();
    bus4.valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(12);

    // Random traffic on both instances with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bus4.valid_i = ($urandom_range(0, 2) != 0);
      bus4.data_i  = 4'($urandom_range(0, 15));
      bus8.valid_i = ($urandom_range(0, 2) != 0);
      bus8.data_i  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) train4 = ~train4;
      if ($urandom_range(0, 15) == 0) train8 = ~train8;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus4.valid_i = 1'b0;
    bus8.valid_i = 1'b0;
    ticks(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
